bellek_hakemi: RTL and testbench

Arbitrates the core's single external memory port between the instruction-fetch miss path (L1I refill, read-only) and the data path (L1D load/store). One transaction is outstanding at a time, and conflicting requests are granted round-robin. The block sits between the L1 controllers and the memory bus. Its busy state feeds the fetch-ready and execute-ready inputs of the pipeline hazard/stall unit.

---
 rtl/bellek_hakemi.sv | 212 +++++++++++++++++++++
 tb/tb_bellek_hakemi.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bellek_hakemi.sv
// Round-robin arbiter for the single external memory port: instruction refill vs. data load/store.
// Optional response timeout enabled by defining BELLEK_HAKEMI_ZAMAN_ASIMI_EN.
module bellek_hakemi #(
  parameter int unsigned ADRES_BIT   = 32,
  parameter int unsigned VERI_BIT    = 32,
  parameter int unsigned ZAMAN_ASIMI = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  bb_istek_i,
  input  logic [ADRES_BIT-1:0]  bb_adres_i,
  output logic                  bb_hazir_o,
  output logic                  bb_gecerli_o,
  output logic [VERI_BIT-1:0]   bb_veri_o,
  output logic                  bb_hata_o,
  input  logic                  vb_istek_i,
  input  logic                  vb_yaz_i,
  input  logic [ADRES_BIT-1:0]  vb_adres_i,
  input  logic [VERI_BIT-1:0]   vb_veri_i,
  input  logic [VERI_BIT/8-1:0] vb_maske_i,
  output logic                  vb_hazir_o,
  output logic                  vb_gecerli_o,
  output logic [VERI_BIT-1:0]   vb_veri_o,
  output logic                  vb_hata_o,
  output logic                  bel_istek_o,
  output logic                  bel_yaz_o,
  output logic [ADRES_BIT-1:0]  bel_adres_o,
  output logic [VERI_BIT-1:0]   bel_veri_o,
  output logic [VERI_BIT/8-1:0] bel_maske_o,
  input  logic                  bel_hazir_i,
  input  logic                  bel_gecerli_i,
  input  logic [VERI_BIT-1:0]   bel_veri_i,
  output logic                  mesgul_o
);

  localparam int unsigned MASKE_BIT = VERI_BIT / 8;

  localparam logic [1:0] BOSTA = 2'd0;
  localparam logic [1:0] ISTEK = 2'd1;
  localparam logic [1:0] YANIT = 2'd2;

  localparam logic SAHIP_BB = 1'b0;
  localparam logic SAHIP_VB = 1'b1;

  logic [1:0]           durum_q, durum_d;
  logic                 sahip_q, sahip_d;
  logic                 son_sahip_q, son_sahip_d;
  logic                 bel_yaz_q, bel_yaz_d;
  logic [ADRES_BIT-1:0] bel_adres_q, bel_adres_d;
  logic [VERI_BIT-1:0]  bel_veri_q, bel_veri_d;
  logic [MASKE_BIT-1:0] bel_maske_q, bel_maske_d;
  logic                 bb_gecerli_q, bb_gecerli_d;
  logic                 vb_gecerli_q, vb_gecerli_d;
  logic                 bb_hata_q, bb_hata_d;
  logic                 vb_hata_q, vb_hata_d;
  logic [VERI_BIT-1:0]  bb_veri_q, bb_veri_d;
  logic [VERI_BIT-1:0]  vb_veri_q, vb_veri_d;
  logic                 zaman_doldu;

`ifdef BELLEK_HAKEMI_ZAMAN_ASIMI_EN
  localparam int unsigned HAM_BIT   = $clog2(ZAMAN_ASIMI + 1);
  localparam int unsigned SAYAC_BIT = (HAM_BIT < 8) ? 8 : ((HAM_BIT > 16) ? 16 : HAM_BIT);
  localparam logic [SAYAC_BIT-1:0] SINIR = SAYAC_BIT'(ZAMAN_ASIMI);

  logic [SAYAC_BIT-1:0] sayac_q, sayac_d;

  // Counts YANIT cycles without a response; cleared on the ISTEK->YANIT handoff.
  always_comb begin
    sayac_d = sayac_q;
    if (durum_q == ISTEK && bel_hazir_i) begin
      sayac_d = '0;
    end else if (durum_q == YANIT && !bel_gecerli_i) begin
      sayac_d = sayac_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sayac_q <= '0;
    end else begin
      sayac_q <= sayac_d;
    end
  end

  assign zaman_doldu = (durum_q == YANIT) && (sayac_q == SINIR);
`else
  logic [31:0] unused_zaman_asimi;
  assign unused_zaman_asimi = ZAMAN_ASIMI;
  assign zaman_doldu        = 1'b0;
`endif

  always_comb begin
    durum_d      = durum_q;
    sahip_d      = sahip_q;
    son_sahip_d  = son_sahip_q;
    bel_yaz_d    = bel_yaz_q;
    bel_adres_d  = bel_adres_q;
    bel_veri_d   = bel_veri_q;
    bel_maske_d  = bel_maske_q;
    bb_veri_d    = bb_veri_q;
    vb_veri_d    = vb_veri_q;
    bb_gecerli_d = 1'b0;
    vb_gecerli_d = 1'b0;
    bb_hata_d    = 1'b0;
    vb_hata_d    = 1'b0;

    unique case (durum_q)
      BOSTA: begin
        if (bb_istek_i || vb_istek_i) begin
          if (bb_istek_i && vb_istek_i) begin
            sahip_d = ~son_sahip_q;
          end else begin
            sahip_d = vb_istek_i ? SAHIP_VB : SAHIP_BB;
          end
          son_sahip_d = sahip_d;
          durum_d     = ISTEK;
          if (sahip_d == SAHIP_VB) begin
            bel_yaz_d   = vb_yaz_i;
            bel_adres_d = vb_adres_i;
            bel_veri_d  = vb_veri_i;
            bel_maske_d = vb_maske_i;
          end else begin
            // Refill is read-only: full-word read, no write data.
            bel_yaz_d   = 1'b0;
            bel_adres_d = bb_adres_i;
            bel_veri_d  = '0;
            bel_maske_d = '1;
          end
        end
      end
      ISTEK: begin
        if (bel_hazir_i) begin
          durum_d = YANIT;
        end
      end
      YANIT: begin
        if (bel_gecerli_i) begin
          durum_d = BOSTA;
          if (sahip_q == SAHIP_VB) begin
            vb_gecerli_d = 1'b1;
            vb_veri_d    = bel_veri_i;
          end else begin
            bb_gecerli_d = 1'b1;
            bb_veri_d    = bel_veri_i;
          end
        end else if (zaman_doldu) begin
          durum_d = BOSTA;
          if (sahip_q == SAHIP_VB) begin
            vb_gecerli_d = 1'b1;
            vb_hata_d    = 1'b1;
            vb_veri_d    = '0;
          end else begin
            bb_gecerli_d = 1'b1;
            bb_hata_d    = 1'b1;
            bb_veri_d    = '0;
          end
        end
      end
      default: begin
        durum_d = BOSTA;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q      <= BOSTA;
      sahip_q      <= SAHIP_BB;
      son_sahip_q  <= SAHIP_BB;
      bel_yaz_q    <= 1'b0;
      bel_adres_q  <= '0;
      bel_veri_q   <= '0;
      bel_maske_q  <= '0;
      bb_gecerli_q <= 1'b0;
      vb_gecerli_q <= 1'b0;
      bb_hata_q    <= 1'b0;
      vb_hata_q    <= 1'b0;
      bb_veri_q    <= '0;
      vb_veri_q    <= '0;
    end else begin
      durum_q      <= durum_d;
      sahip_q      <= sahip_d;
      son_sahip_q  <= son_sahip_d;
      bel_yaz_q    <= bel_yaz_d;
      bel_adres_q  <= bel_adres_d;
      bel_veri_q   <= bel_veri_d;
      bel_maske_q  <= bel_maske_d;
      bb_gecerli_q <= bb_gecerli_d;
      vb_gecerli_q <= vb_gecerli_d;
      bb_hata_q    <= bb_hata_d;
      vb_hata_q    <= vb_hata_d;
      bb_veri_q    <= bb_veri_d;
      vb_veri_q    <= vb_veri_d;
    end
  end

  assign bel_istek_o  = (durum_q == ISTEK);
  assign bb_hazir_o   = (durum_q == ISTEK) && bel_hazir_i && (sahip_q == SAHIP_BB);
  assign vb_hazir_o   = (durum_q == ISTEK) && bel_hazir_i && (sahip_q == SAHIP_VB);
  assign mesgul_o     = (durum_q != BOSTA);
  assign bel_yaz_o    = bel_yaz_q;
  assign bel_adres_o  = bel_adres_q;
  assign bel_veri_o   = bel_veri_q;
  assign bel_maske_o  = bel_maske_q;
  assign bb_gecerli_o = bb_gecerli_q;
  assign vb_gecerli_o = vb_gecerli_q;
  assign bb_veri_o    = bb_veri_q;
  assign vb_veri_o    = vb_veri_q;
  assign bb_hata_o    = bb_hata_q;
  assign vb_hata_o    = vb_hata_q;

endmodule

// File: tb/tb_bellek_hakemi.sv
// Self-checking bench for bellek_hakemi: transaction-level model compared every cycle,
// plus directed literal checks. Timeout cases run only with BELLEK_HAKEMI_ZAMAN_ASIMI_EN.
module tb_bellek_hakemi;

  localparam int LIMIT = 8;

  typedef struct {
    logic        yaz;
    logic [31:0] adres;
    logic [31:0] veri;
    logic [3:0]  maske;
  } vb_istek_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        bb_istek_i = 1'b0;
  logic [31:0] bb_adres_i = '0;
  logic        bb_hazir_o, bb_gecerli_o, bb_hata_o;
  logic [31:0] bb_veri_o;
  logic        vb_istek_i = 1'b0;
  logic        vb_yaz_i = 1'b0;
  logic [31:0] vb_adres_i = '0;
  logic [31:0] vb_veri_i = '0;
  logic [3:0]  vb_maske_i = '0;
  logic        vb_hazir_o, vb_gecerli_o, vb_hata_o;
  logic [31:0] vb_veri_o;
  logic        bel_istek_o, bel_yaz_o;
  logic [31:0] bel_adres_o, bel_veri_o;
  logic [3:0]  bel_maske_o;
  logic        bel_hazir_i = 1'b0;
  logic        bel_gecerli_i = 1'b0;
  logic [31:0] bel_veri_i = '0;
  logic        mesgul_o;

  bellek_hakemi #(
    .ADRES_BIT  (32),
    .VERI_BIT   (32),
    .ZAMAN_ASIMI(LIMIT)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bb_istek_i   (bb_istek_i),
    .bb_adres_i   (bb_adres_i),
    .bb_hazir_o   (bb_hazir_o),
    .bb_gecerli_o (bb_gecerli_o),
    .bb_veri_o    (bb_veri_o),
    .bb_hata_o    (bb_hata_o),
    .vb_istek_i   (vb_istek_i),
    .vb_yaz_i     (vb_yaz_i),
    .vb_adres_i   (vb_adres_i),
    .vb_veri_i    (vb_veri_i),
    .vb_maske_i   (vb_maske_i),
    .vb_hazir_o   (vb_hazir_o),
    .vb_gecerli_o (vb_gecerli_o),
    .vb_veri_o    (vb_veri_o),
    .vb_hata_o    (vb_hata_o),
    .bel_istek_o  (bel_istek_o),
    .bel_yaz_o    (bel_yaz_o),
    .bel_adres_o  (bel_adres_o),
    .bel_veri_o   (bel_veri_o),
    .bel_maske_o  (bel_maske_o),
    .bel_hazir_i  (bel_hazir_i),
    .bel_gecerli_i(bel_gecerli_i),
    .bel_veri_i   (bel_veri_i),
    .mesgul_o     (mesgul_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int kontrol_sayisi = 0;
  int hata_sayisi = 0;

  task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    kontrol_sayisi++;
    if (gercek !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", ad, cyc, gercek, beklenen);
    end
  endtask

  // Requester queues and memory behaviour knobs.
  logic [31:0] bb_q[$];
  vb_istek_t   vb_q[$];
  bit          bb_kabul = 0, vb_kabul = 0;
  int          mem_hazir_bekle = 0, mem_yanit_bekle = 0;
  bit          mem_sessiz = 0, zorla_gecerli = 0;
  logic [31:0] mem_veri = '0, zorla_veri = '0;

  // Requesters: hold request and payload until the accept pulse, then move to the next entry.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (bb_kabul && bb_q.size() > 0) void'(bb_q.pop_front());
      if (vb_kabul && vb_q.size() > 0) void'(vb_q.pop_front());
      bb_kabul   = 0;
      vb_kabul   = 0;
      bb_istek_i = (bb_q.size() > 0);
      bb_adres_i = (bb_q.size() > 0) ? bb_q[0] : '0;
      vb_istek_i = (vb_q.size() > 0);
      if (vb_q.size() > 0) begin
        vb_yaz_i   = vb_q[0].yaz;
        vb_adres_i = vb_q[0].adres;
        vb_veri_i  = vb_q[0].veri;
        vb_maske_i = vb_q[0].maske;
      end else begin
        vb_yaz_i   = 0;
        vb_adres_i = '0;
        vb_veri_i  = '0;
        vb_maske_i = '0;
      end
    end
  end

  // Memory: accept after mem_hazir_bekle request cycles, answer mem_yanit_bekle cycles later.
  initial begin
    int hz;
    int yan;
    bit kabul_onceki;
    hz = 0;
    yan = -1;
    kabul_onceki = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!rst_i) begin
        bel_hazir_i   = 0;
        bel_gecerli_i = 0;
        hz = 0;
        yan = -1;
        kabul_onceki = 0;
      end else begin
        bel_gecerli_i = 0;
        if (kabul_onceki) yan = 0;
        kabul_onceki = 0;
        if (yan >= 0) begin
          if (!mem_sessiz && yan == mem_yanit_bekle) begin
            bel_gecerli_i = 1;
            bel_veri_i    = mem_veri;
            yan = -1;
          end else begin
            yan++;
          end
        end
        if (zorla_gecerli) begin
          bel_gecerli_i = 1;
          bel_veri_i    = zorla_veri;
        end
        bel_hazir_i = 0;
        if (bel_istek_o) begin
          if (hz >= mem_hazir_bekle) begin
            bel_hazir_i  = 1;
            kabul_onceki = 1;
            hz = 0;
          end else begin
            hz++;
          end
        end else begin
          hz = 0;
        end
      end
    end
  end

  // Reference model: one transaction at a time, phases idle / offered / awaiting data.
  int          m_faz = 0;
  bit          m_sahip = 0, m_son = 0;  // 0 = instruction, 1 = data
  logic        m_yaz = 0;
  logic [31:0] m_adres = '0, m_veri = '0;
  logic [3:0]  m_maske = '0;
  int          m_bekleme = 0;
  logic        p_bb_gec = 0, p_vb_gec = 0, p_bb_hata = 0, p_vb_hata = 0;
  logic [31:0] m_bb_veri = '0, m_vb_veri = '0;

  // Event records for the directed checks.
  int          grant_log[$];
  int          istek_rise[$];
  bit          onceki_istek = 0;
  int          son_bb_hazir_cyc = 0, son_vb_hazir_cyc = 0, son_bb_gec_cyc = 0, son_vb_gec_cyc = 0;
  logic [31:0] son_bb_veri = '0, son_vb_veri = '0, kabul_adres = '0;
  logic        son_bb_hata = 0, son_vb_hata = 0, kabul_yaz = 0;
  logic [3:0]  kabul_maske = '0;
  int          vb_hazir_sayisi = 0, bb_olay_sayisi = 0, gec_sayisi = 0, istek_cyc_sayisi = 0;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      m_faz = 0; m_sahip = 0; m_son = 0;
      p_bb_gec = 0; p_vb_gec = 0; p_bb_hata = 0; p_vb_hata = 0;
      m_bb_veri = '0; m_vb_veri = '0;
      kontrol("rst bel_yaz", 32'(bel_yaz_o), 32'd0);
      kontrol("rst bel_adres", bel_adres_o, 32'd0);
      kontrol("rst bel_veri", bel_veri_o, 32'd0);
      kontrol("rst bel_maske", 32'(bel_maske_o), 32'd0);
    end
    kontrol("bel_istek", 32'(bel_istek_o), 32'(m_faz == 1));
    kontrol("mesgul", 32'(mesgul_o), 32'(m_faz != 0));
    kontrol("bb_hazir", 32'(bb_hazir_o), 32'(m_faz == 1 && bel_hazir_i && m_sahip == 0));
    kontrol("vb_hazir", 32'(vb_hazir_o), 32'(m_faz == 1 && bel_hazir_i && m_sahip == 1));
    kontrol("bb_gecerli", 32'(bb_gecerli_o), 32'(p_bb_gec));
    kontrol("vb_gecerli", 32'(vb_gecerli_o), 32'(p_vb_gec));
    kontrol("bb_hata", 32'(bb_hata_o), 32'(p_bb_hata));
    kontrol("vb_hata", 32'(vb_hata_o), 32'(p_vb_hata));
    kontrol("bb_veri", bb_veri_o, m_bb_veri);
    kontrol("vb_veri", vb_veri_o, m_vb_veri);
    if (m_faz == 1) begin
      kontrol("bel_yaz", 32'(bel_yaz_o), 32'(m_yaz));
      kontrol("bel_adres", bel_adres_o, m_adres);
      kontrol("bel_veri", bel_veri_o, m_veri);
      kontrol("bel_maske", 32'(bel_maske_o), 32'(m_maske));
    end

    if (rst_i) begin
      if (bb_hazir_o) begin
        son_bb_hazir_cyc = cyc; grant_log.push_back(0); bb_kabul = 1; bb_olay_sayisi++;
        kabul_maske = bel_maske_o; kabul_yaz = bel_yaz_o; kabul_adres = bel_adres_o;
      end
      if (vb_hazir_o) begin
        son_vb_hazir_cyc = cyc; grant_log.push_back(1); vb_kabul = 1; vb_hazir_sayisi++;
        kabul_maske = bel_maske_o; kabul_yaz = bel_yaz_o; kabul_adres = bel_adres_o;
      end
      if (bb_gecerli_o) begin
        son_bb_gec_cyc = cyc; son_bb_veri = bb_veri_o; son_bb_hata = bb_hata_o;
        gec_sayisi++; bb_olay_sayisi++;
      end
      if (vb_gecerli_o) begin
        son_vb_gec_cyc = cyc; son_vb_veri = vb_veri_o; son_vb_hata = vb_hata_o;
        gec_sayisi++;
      end
      if (bel_istek_o && !onceki_istek) istek_rise.push_back(cyc);
      if (bel_istek_o) istek_cyc_sayisi++;
      onceki_istek = bel_istek_o;

      // Advance the model with this cycle's inputs.
      p_bb_gec = 0; p_vb_gec = 0; p_bb_hata = 0; p_vb_hata = 0;
      case (m_faz)
        0: if (bb_istek_i || vb_istek_i) begin
          m_sahip = (bb_istek_i && vb_istek_i) ? !m_son : vb_istek_i;
          m_son   = m_sahip;
          m_yaz   = m_sahip ? vb_yaz_i : 1'b0;
          m_adres = m_sahip ? vb_adres_i : bb_adres_i;
          m_veri  = m_sahip ? vb_veri_i : 32'd0;
          m_maske = m_sahip ? vb_maske_i : 4'hF;
          m_faz   = 1;
        end
        1: if (bel_hazir_i) begin
          m_faz = 2;
          m_bekleme = 0;
        end
        default: begin
          if (bel_gecerli_i) begin
            if (m_sahip) begin p_vb_gec = 1; m_vb_veri = bel_veri_i; end
            else begin p_bb_gec = 1; m_bb_veri = bel_veri_i; end
            m_faz = 0;
          end
`ifdef BELLEK_HAKEMI_ZAMAN_ASIMI_EN
          else if (m_bekleme == LIMIT) begin
            if (m_sahip) begin p_vb_gec = 1; p_vb_hata = 1; m_vb_veri = '0; end
            else begin p_bb_gec = 1; p_bb_hata = 1; m_bb_veri = '0; end
            m_faz = 0;
          end
`endif
          else begin
            m_bekleme++;
          end
        end
      endcase
    end else begin
      onceki_istek = 0;
    end
  end

  task automatic bosalt(input string ad, input int sinir);
    int n;
    n = 0;
    while ((bb_q.size() > 0 || vb_q.size() > 0 || mesgul_o) && n < sinir) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= sinir) begin
      hata_sayisi++;
      $display("FAIL %s: no idle within %0d cycles (got busy, expected idle)", ad, sinir);
    end
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int beklenen_sira[4];
    int n;
    beklenen_sira = '{1, 0, 1, 0};

    repeat (3) @(posedge clk_i);
    #1 rst_i = 1;
    repeat (2) @(negedge clk_i);

    // Single instruction read, zero-wait memory.
    mem_veri = 32'hDEAD_BEEF;
    bb_q.push_back(32'h0000_1000);
    bosalt("tek okuma", 30);
    kontrol("tek okuma gecerli gecikme", 32'(son_bb_gec_cyc - son_bb_hazir_cyc), 32'd2);
    kontrol("tek okuma istek=hazir", 32'(istek_rise[istek_rise.size()-1]), 32'(son_bb_hazir_cyc));
    kontrol("tek okuma veri", son_bb_veri, 32'hDEAD_BEEF);
    kontrol("tek okuma maske", 32'(kabul_maske), 32'hF);
    kontrol("tek okuma yaz", 32'(kabul_yaz), 32'd0);
    kontrol("tek okuma adres", kabul_adres, 32'h0000_1000);

    // Data write with 4 cycles of backpressure.
    mem_hazir_bekle = 4;
    vb_hazir_sayisi = 0; bb_olay_sayisi = 0; istek_cyc_sayisi = 0;
    vb_q.push_back('{yaz: 1'b1, adres: 32'h2000_0004, veri: 32'h1234_5678, maske: 4'h3});
    bosalt("yazma", 40);
    kontrol("yazma vb_hazir adet", 32'(vb_hazir_sayisi), 32'd1);
    kontrol("yazma bb olay", 32'(bb_olay_sayisi), 32'd0);
    kontrol("yazma istek cycles", 32'(istek_cyc_sayisi), 32'd5);
    kontrol("yazma adres", kabul_adres, 32'h2000_0004);
    kontrol("yazma maske", 32'(kabul_maske), 32'h3);
    mem_hazir_bekle = 0;

    // Reset in the middle of YANIT, then a stray late response.
    mem_sessiz = 1;
    vb_q.push_back('{yaz: 1'b0, adres: 32'h0000_3000, veri: 32'h0, maske: 4'hF});
    n = 0;
    while (!(mesgul_o && !bel_istek_o) && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    kontrol("yanit bekleme", 32'(n < 20), 32'd1);
    repeat (2) @(negedge clk_i);
    #1 rst_i = 0;
    #1;
    kontrol("rst mesgul", 32'(mesgul_o), 32'd0);
    kontrol("rst bel_istek", 32'(bel_istek_o), 32'd0);
    kontrol("rst bb_veri", bb_veri_o, 32'd0);
    kontrol("rst vb_gecerli", 32'(vb_gecerli_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1;
    mem_sessiz = 0;
    gec_sayisi = 0;
    @(negedge clk_i);
    zorla_gecerli = 1;
    zorla_veri = 32'h5555_AAAA;
    @(negedge clk_i);
    zorla_gecerli = 0;
    repeat (3) @(negedge clk_i);
    kontrol("basibos yanit", 32'(gec_sayisi), 32'd0);

    // Conflict: both sides queued right after reset alternate vb, bb, vb, bb.
    grant_log.delete();
    istek_rise.delete();
    mem_veri = 32'h0BAD_F00D;
    bb_q.push_back(32'h0000_0100);
    bb_q.push_back(32'h0000_0104);
    vb_q.push_back('{yaz: 1'b0, adres: 32'h0000_0200, veri: 32'h0, maske: 4'hF});
    vb_q.push_back('{yaz: 1'b1, adres: 32'h0000_0204, veri: 32'hCAFE_0001, maske: 4'hC});
    bosalt("cakisma", 60);
    kontrol("cakisma adet", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) kontrol("cakisma sira", 32'(grant_log[i]), 32'(beklenen_sira[i]));
    end
    for (int i = 1; i < 4; i++) begin
      if (i < istek_rise.size())
        kontrol("cakisma aralik", 32'(istek_rise[i] - istek_rise[i-1]), 32'd3);
    end

`ifdef BELLEK_HAKEMI_ZAMAN_ASIMI_EN
    // Timeout: memory accepts but never answers.
    mem_sessiz = 1;
    vb_q.push_back('{yaz: 1'b0, adres: 32'h0000_4000, veri: 32'h0, maske: 4'hF});
    bosalt("zaman asimi", 40);
    kontrol("zaman asimi gecikme", 32'(son_vb_gec_cyc - son_vb_hazir_cyc), 32'd10);
    kontrol("zaman asimi hata", 32'(son_vb_hata), 32'd1);
    kontrol("zaman asimi veri", son_vb_veri, 32'd0);
    mem_sessiz = 0;
    mem_veri = 32'h0000_0011;
    vb_q.push_back('{yaz: 1'b0, adres: 32'h0000_4004, veri: 32'h0, maske: 4'hF});
    bosalt("sonraki istek", 30);
    kontrol("sonraki hata", 32'(son_vb_hata), 32'd0);
    kontrol("sonraki veri", son_vb_veri, 32'h0000_0011);

    // Response lands exactly on the limit cycle: real data wins.
    mem_yanit_bekle = LIMIT;
    mem_veri = 32'hA5A5_A5A5;
    bb_q.push_back(32'h0000_5000);
    bosalt("esitlik", 40);
    kontrol("esitlik hata", 32'(son_bb_hata), 32'd0);
    kontrol("esitlik veri", son_bb_veri, 32'hA5A5_A5A5);
    kontrol("esitlik gecikme", 32'(son_bb_gec_cyc - son_bb_hazir_cyc), 32'd10);
    mem_yanit_bekle = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", kontrol_sayisi, hata_sayisi);
    $finish;
  end

endmodule
